// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode classes, field positions and control encodings
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;

  // Bit positions inside the one-hot class vector
  localparam int CLS_OP_IMM = 0;
  localparam int CLS_OP     = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int NUM_CLS    = 7;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_JALR = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_CMP = 2'd2} alu_op_e;

endpackage

// File: rtl/riscv_opclass_decode.sv
// rtl/riscv_opclass_decode.sv - combinational opcode class one-hot and illegal-encoding flag
module riscv_opclass_decode
  import riscv_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [NUM_CLS-1:0] cls,
  output logic               illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct3      = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign unused_bits = ^{instr[31:FUNCT3_MSB+1], instr[FUNCT3_LSB-1:OPCODE_MSB+1]};

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: cls[CLS_OP_IMM] = 1'b1;
      OPC_OP:     cls[CLS_OP]     = 1'b1;
      OPC_LOAD: begin
        cls[CLS_LOAD] = 1'b1;
        illegal       = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        cls[CLS_STORE] = 1'b1;
        illegal        = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        cls[CLS_BRANCH] = 1'b1;
        illegal         = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL:    cls[CLS_JAL] = 1'b1;
      OPC_JALR: begin
        cls[CLS_JALR] = 1'b1;
        illegal       = (funct3 != 3'd0);
      end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multi-cycle RV32I control FSM sharing one memory port
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        branch_taken_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  localparam logic [2:0] S_FETCH     = ST_FETCH;
  localparam logic [2:0] S_DECODE    = ST_DECODE;
  localparam logic [2:0] S_EXECUTE   = ST_EXECUTE;
  localparam logic [2:0] S_MEM       = ST_MEM;
  localparam logic [2:0] S_WRITEBACK = ST_WRITEBACK;
  localparam logic [2:0] S_TRAP      = ST_TRAP;

  logic [2:0]         state, next;
  logic [CW-1:0]      cnt, cnt_inc;
  logic               trap_q, timeout, rf_we_raw, illegal;
  logic [NUM_CLS-1:0] cls;

  riscv_opclass_decode u_dec (
    .instr   (instr_i),
    .cls     (cls),
    .illegal (illegal)
  );

  // Trap on the wait cycle that would bring the count up to MEM_TIMEOUT
  assign cnt_inc = cnt + 1'b1;
  assign timeout = !mem_ready_i && (cnt_inc == TIMEOUT_VAL);

  always_comb begin
    next           = state;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = PC_PLUS4;
    rf_we_raw      = 1'b0;
    wb_sel_o       = WB_ALU;
    alu_src_b_o    = 1'b0;
    alu_op_o       = ALU_ADD;
    retire_o       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          next    = S_DECODE;
        end else if (timeout) begin
          next = S_TRAP;
        end
      end
      S_DECODE: next = illegal ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        next = S_TRAP;
        if (cls[CLS_OP]) begin
          alu_op_o = ALU_FUNCT;
          next     = S_WRITEBACK;
        end
        if (cls[CLS_OP_IMM]) begin
          alu_src_b_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
          next        = S_WRITEBACK;
        end
        if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
          alu_src_b_o = 1'b1;
          next        = S_MEM;
        end
        if (cls[CLS_BRANCH]) begin
          alu_op_o = ALU_CMP;
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
          retire_o = 1'b1;
          next     = S_FETCH;
        end
        if (cls[CLS_JAL] || cls[CLS_JALR]) begin
          alu_src_b_o = cls[CLS_JALR];
          pc_we_o     = 1'b1;
          pc_sel_o    = cls[CLS_JALR] ? PC_JALR : PC_IMM;
          rf_we_raw   = 1'b1;
          wb_sel_o    = WB_PC4;
          retire_o    = 1'b1;
          next        = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = cls[CLS_STORE];
        if (mem_ready_i) begin
          if (cls[CLS_STORE]) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            next     = S_FETCH;
          end else begin
            next = S_WRITEBACK;
          end
        end else if (timeout) begin
          next = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        rf_we_raw = 1'b1;
        wb_sel_o  = cls[CLS_LOAD] ? WB_LOAD : WB_ALU;
        pc_we_o   = 1'b1;
        retire_o  = 1'b1;
        next      = S_FETCH;
      end
      default: next = S_TRAP;
    endcase
    rf_we_o = rf_we_raw && (instr_i[RD_MSB:RD_LSB] != 5'd0);
    // Reset forces every output low regardless of the stored state
    if (!rst_n) begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_sel_o       = PC_PLUS4;
      rf_we_o        = 1'b0;
      wb_sel_o       = WB_ALU;
      alu_src_b_o    = 1'b0;
      alu_op_o       = ALU_ADD;
      retire_o       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      cnt    <= '0;
      trap_q <= 1'b0;
    end else begin
      state <= next;
      if ((next != state) && ((next == S_FETCH) || (next == S_MEM))) begin
        cnt <= '0;
      end else if (mem_req_o && !mem_ready_i) begin
        cnt <= cnt_inc;
      end
      if (next == S_TRAP) begin
        trap_q <= 1'b1;
      end
    end
  end

  assign trap_o  = trap_q && rst_n;
  assign state_o = rst_n ? state : 3'd0;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - directed-vector bench for riscv_multicycle_ctrl
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o;
  logic        rf_we_o, alu_src_b_o, retire_o, trap_o;
  logic [1:0]  pc_sel_o, wb_sel_o, alu_op_o;
  logic [2:0]  state_o;
  logic [17:0] ctl;

  int nvec = 0;
  int nfail = 0;

  int          cyc, irw;
  logic [63:0] seq;
  logic [17:0] snap, exe;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_i        (instr),
    .branch_taken_i (branch_taken),
    .mem_ready_i    (mem_ready),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .retire_o       (retire_o),
    .trap_o         (trap_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  // [17]req [16]we [15]addr_sel [14]ir_we [13]pc_we [12:11]pc_sel [10]rf_we
  // [9:8]wb_sel [7]src_b [6:5]alu_op [4]retire [3]trap [2:0]state
  assign ctl = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o,
                wb_sel_o, alu_src_b_o, alu_op_o, retire_o, trap_o, state_o};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH; seq holds one octal digit per cycle's state
  task automatic run(input logic [31:0] ins, input logic [15:0] rdy, input logic bt,
                     output int c, output int ir, output logic [63:0] sq,
                     output logic [17:0] sn, output logic [17:0] ex);
    logic done;
    instr        = ins;
    branch_taken = bt;
    c = 99; ir = 0; sq = '0; sn = '0; ex = '0; done = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (!done) begin
        mem_ready = rdy[n];
        #1;
        sq = {sq[60:0], state_o};
        ir = ir + int'(ir_we_o);
        if (state_o == 3'd2) ex = ctl;
        if (retire_o || state_o == 3'd7) begin
          c    = n + 1;
          sn   = ctl;
          done = 1'b1;
        end
        step();
      end
    end
  endtask

  initial begin
    step();
    step();
    #1;
    chk("reset_outputs", 64'(ctl), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("first_fetch_req", 64'(mem_req_o), 64'd1);
    chk("first_fetch_state", 64'(state_o), 64'd0);
    step();
    do_reset();

    // ADDI x1,x0,5
    run(32'h00500093, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("addi_cycles", 64'(cyc), 64'd4);
    chk("addi_states", seq, 64'o124);
    chk("addi_irwe", 64'(irw), 64'd1);
    chk("addi_srcb", 64'(exe[7]), 64'd1);
    chk("addi_aluop", 64'(exe[6:5]), 64'd1);
    chk("addi_rfwe", 64'(snap[10]), 64'd1);
    chk("addi_wbsel", 64'(snap[9:8]), 64'd0);
    chk("addi_pcwe", 64'(snap[13]), 64'd1);
    chk("addi_pcsel", 64'(snap[12:11]), 64'd0);
    #1;
    chk("addi_back_fetch", 64'(state_o), 64'd0);

    // LW x2,0(x1): 3 waits in FETCH, ready ignored in DECODE/EXECUTE, 2 waits in MEM
    run(32'h0000A103, 16'h0338, 1'b0, cyc, irw, seq, snap, exe);
    chk("lw_cycles", 64'(cyc), 64'd10);
    chk("lw_states", seq, 64'o0000123334);
    chk("lw_irwe", 64'(irw), 64'd1);
    chk("lw_srcb", 64'(exe[7]), 64'd1);
    chk("lw_aluop", 64'(exe[6:5]), 64'd0);
    chk("lw_wbsel", 64'(snap[9:8]), 64'd1);
    chk("lw_rfwe", 64'(snap[10]), 64'd1);

    // SW x2,4(x1) retires in MEM
    run(32'h0020A223, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("sw_cycles", 64'(cyc), 64'd4);
    chk("sw_states", seq, 64'o123);
    chk("sw_mem", 64'(snap[17:15]), 64'b111);
    chk("sw_pc", 64'(snap[13:10]), 64'b1000);

    // OP add x3,x1,x2
    run(32'h002081B3, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("add_cycles", 64'(cyc), 64'd4);
    chk("add_exe", 64'(exe[7:5]), 64'b001);

    // ADDI x0: rf_we suppressed, still retires
    run(32'h00000013, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("nop_cycles", 64'(cyc), 64'd4);
    chk("nop_rfwe", 64'(snap[10]), 64'd0);

    // BEQ taken / not taken
    run(32'h00000463, 16'hFFFF, 1'b1, cyc, irw, seq, snap, exe);
    chk("beq_t_cycles", 64'(cyc), 64'd3);
    chk("beq_t_pcsel", 64'(snap[12:11]), 64'd1);
    chk("beq_t_rfwe", 64'(snap[10]), 64'd0);
    chk("beq_t_aluop", 64'(snap[6:5]), 64'd2);
    run(32'h00000463, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("beq_n_cycles", 64'(cyc), 64'd3);
    chk("beq_n_pcsel", 64'(snap[12:11]), 64'd0);

    // JAL x0, JAL x1, JALR x1,0(x2)
    run(32'h0000006F, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("jal0_cycles", 64'(cyc), 64'd3);
    chk("jal0_pc_rf_wb", 64'(snap[12:8]), 64'b01_0_10);
    run(32'h000000EF, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("jal1_rfwe", 64'(snap[10]), 64'd1);
    run(32'h000100E7, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("jalr_cycles", 64'(cyc), 64'd3);
    chk("jalr_pc_rf_wb", 64'(snap[12:8]), 64'b10_1_10);
    chk("jalr_alu", 64'(snap[7:5]), 64'b100);

    // LBU is a legal load width
    run(32'h00004103, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("lbu_cycles", 64'(cyc), 64'd5);

    // JALR funct3=1 traps; trap is sticky until reset
    run(32'h000010E7, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("jalr_bad_states", seq, 64'o17);
    chk("jalr_bad_trap", 64'(snap[3]), 64'd1);
    for (int n = 0; n < 4; n++) begin
      chk("trap_sticky", 64'(ctl), 64'h0000F);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("trap_cleared_in_reset", 64'(trap_o), 64'd0);
    step();
    rst_n = 1'b1;

    // Illegal encodings: bad opcode, LOAD f3=3, STORE f3=3, BRANCH f3=2
    run(32'h0000007F, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("opc7f_states", seq, 64'o17);
    do_reset();
    run(32'h00003003, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("ld_f3_states", seq, 64'o17);
    do_reset();
    run(32'h00003023, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("st_f3_states", seq, 64'o17);
    do_reset();
    run(32'h00002063, 16'hFFFF, 1'b0, cyc, irw, seq, snap, exe);
    chk("br_f3_states", seq, 64'o17);
    do_reset();

    // Fetch timeout: 4 unanswered request cycles, then TRAP
    run(32'h00500093, 16'h0000, 1'b0, cyc, irw, seq, snap, exe);
    chk("fetch_to_cycles", 64'(cyc), 64'd5);
    chk("fetch_to_trap", 64'(snap[3:0]), 64'hF);
    do_reset();
    // Ready on the 4th request cycle wins
    run(32'h00500093, 16'hFFF8, 1'b0, cyc, irw, seq, snap, exe);
    chk("fetch_edge_cycles", 64'(cyc), 64'd7);
    chk("fetch_edge_states", seq, 64'o0000124);
    // MEM timeout: counter restarts on entry to MEM after 2 fetch waits
    run(32'h0000A103, 16'h001C, 1'b0, cyc, irw, seq, snap, exe);
    chk("mem_to_cycles", 64'(cyc), 64'd10);
    chk("mem_to_states", seq, 64'o0001233337);
    do_reset();

    // Reset in the middle of a MEM wait
    instr     = 32'h0000A103;
    mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    chk("mid_mem_state", 64'(state_o), 64'd3);
    chk("mid_mem_req", 64'(mem_req_o), 64'd1);
    rst_n = 1'b0;
    step();
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("resume_req", 64'(mem_req_o), 64'd1);
    chk("resume_addr_sel", 64'(mem_addr_sel_o), 64'd0);
    step();
    chk("resume_decode", 64'(state_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
